// File: rtl/lcd_cfg_pkg.sv
// Shared frame layout and state encoding for the LCD serial configuration responder.
package lcd_cfg_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 9;
    localparam int MARK_BIT = 8;

    // After eight bits have been shifted in, the header sits in the low byte.
    localparam int HDR_RW_BIT   = RW_BIT - DATA_W;
    localparam int HDR_MARK_BIT = MARK_BIT - DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK,
        END
    } state_t;

endpackage

// File: rtl/lcd_cfg_pin_sync.sv
// Synchronizer chain plus rise/fall edge detection for the serial link pins.
module lcd_cfg_pin_sync #(
    parameter int               SYNC_STAGES = 2,
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VAL   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the raw pins through the synchronizer and keep one older sample for edge compare.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= pins_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/lcd_config_responder.sv
// Panel-side responder for the 3-wire LCD configuration link.
// Optional read-back of register contents is enabled with LCD_CFG_READBACK_EN.
module lcd_config_responder
    import lcd_cfg_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          NUM_REGS    = 64,
    parameter logic [7:0]  REG_RESET   = 8'h00
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LCD_I2C_sclk,
    inout  wire         LCD_I2C_sdat,
    input  logic        LCD_I2C_scen,
    input  logic [5:0]  Reg_rd_addr,
    output logic [7:0]  Reg_rd_data,
    output logic        Frame_valid,
    output logic [5:0]  Frame_addr,
    output logic [7:0]  Frame_data,
    output logic        Frame_error
);

`ifdef LCD_CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic [2:0] pinLevel, pinRise, pinFall;
    logic       sdatLvl, sclkRise, sclkFall, scenRise, scenFall, scenLvl;

    lcd_cfg_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (3),
        .RESET_VAL   (3'b111)
    ) u_pin_sync (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .pins_i  ({LCD_I2C_scen, LCD_I2C_sdat, LCD_I2C_sclk}),
        .level_o (pinLevel),
        .rise_o  (pinRise),
        .fall_o  (pinFall)
    );

    assign sclkRise = pinRise[0];
    assign sclkFall = pinFall[0];
    assign sdatLvl  = pinLevel[1];
    assign scenLvl  = pinLevel[2];
    assign scenRise = pinRise[2];
    assign scenFall = pinFall[2];

    state_t              state_q, state_d;
    logic [4:0]          bitCnt_q, bitCnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d, shiftNext;
    logic                sdatLow_q, sdatLow_d;
    logic                frameOk_q, frameOk_d;
    logic                readMode_q, readMode_d;
    logic [DATA_W-1:0]   rdVal_q, rdVal_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   frameAddr_q, frameAddr_d;
    logic [DATA_W-1:0]   frameData_q, frameData_d;
    logic                wrEn;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    assign shiftNext = {shift_q[FRAME_W-2:0], sdatLvl};

    // Frame decoder: tracks the bit position, decides accept/reject and steers the sdat drive.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        sdatLow_d   = sdatLow_q;
        frameOk_d   = frameOk_q;
        readMode_d  = readMode_q;
        rdVal_d     = rdVal_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        frameAddr_d = frameAddr_q;
        frameData_d = frameData_q;
        wrEn        = 1'b0;

        case (state_q)
            IDLE: begin
                sdatLow_d  = 1'b0;
                readMode_d = 1'b0;
                if (scenFall) begin
                    state_d  = SHIFT;
                    bitCnt_d = '0;
                end
            end
            SHIFT: begin
                if (sclkRise && bitCnt_q == 5'd15) begin
                    shift_d     = shiftNext;
                    bitCnt_d    = bitCnt_q + 5'd1;
                    state_d     = ACK_WAIT;
                    frameAddr_d = frameAddr_q;
                    if (shiftNext[MARK_BIT] && !shiftNext[RW_BIT]) begin
                        wrEn        = 1'b1;
                        valid_d     = 1'b1;
                        frameOk_d   = 1'b1;
                        frameAddr_d = shiftNext[FRAME_W-1 -: ADDR_W];
                        frameData_d = shiftNext[DATA_W-1:0];
                    end else if (READBACK && readMode_q && shiftNext[MARK_BIT] && shiftNext[RW_BIT]) begin
                        valid_d     = 1'b1;
                        frameOk_d   = 1'b1;
                        frameAddr_d = shiftNext[FRAME_W-1 -: ADDR_W];
                        frameData_d = rdVal_q;
                    end else begin
                        error_d   = 1'b1;
                        frameOk_d = 1'b0;
                    end
                end else if (scenRise) begin
                    error_d   = 1'b1;
                    sdatLow_d = 1'b0;
                    state_d   = IDLE;
                end else if (sclkRise) begin
                    shift_d  = shiftNext;
                    bitCnt_d = bitCnt_q + 5'd1;
                end else if (sclkFall && READBACK) begin
                    if (bitCnt_q == 5'd8 && shift_q[HDR_RW_BIT] && shift_q[HDR_MARK_BIT]) begin
                        readMode_d = 1'b1;
                        rdVal_d    = regs_q[shift_q[DATA_W-1 -: ADDR_W]];
                        sdatLow_d  = ~regs_q[shift_q[DATA_W-1 -: ADDR_W]][DATA_W-1];
                    end else if (readMode_q && bitCnt_q > 5'd8) begin
                        sdatLow_d = ~rdVal_q[3'd7 - bitCnt_q[2:0]];
                    end
                end
            end
            ACK_WAIT: begin
                if (scenRise) begin
                    error_d   = 1'b1;
                    sdatLow_d = 1'b0;
                    state_d   = IDLE;
                end else if (sclkFall) begin
                    sdatLow_d = frameOk_q;
                    state_d   = frameOk_q ? ACK : END;
                end
            end
            ACK: begin
                if (scenRise) begin
                    sdatLow_d = 1'b0;
                    state_d   = IDLE;
                end else if (sclkFall) begin
                    sdatLow_d = 1'b0;
                    state_d   = END;
                end
            end
            END: begin
                sdatLow_d = 1'b0;
                if (scenLvl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                sdatLow_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Decoder state, sdat drive and frame report registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            sdatLow_q   <= 1'b0;
            frameOk_q   <= 1'b0;
            readMode_q  <= 1'b0;
            rdVal_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            frameAddr_q <= '0;
            frameData_q <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            sdatLow_q   <= sdatLow_d;
            frameOk_q   <= frameOk_d;
            readMode_q  <= readMode_d;
            rdVal_q     <= rdVal_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            frameAddr_q <= frameAddr_d;
            frameData_q <= frameData_d;
        end
    end

    // Configuration register file, written when a write frame completes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_RESET;
            end
        end else if (wrEn) begin
            regs_q[shiftNext[FRAME_W-1 -: ADDR_W]] <= shiftNext[DATA_W-1:0];
        end
    end

    assign LCD_I2C_sdat = sdatLow_q ? 1'b0 : 1'bz;
    assign Reg_rd_data  = regs_q[Reg_rd_addr];
    assign Frame_valid  = valid_q;
    assign Frame_error  = error_q;
    assign Frame_addr   = frameAddr_q;
    assign Frame_data   = frameData_q;

endmodule

// File: doc/lcd_config_responder.md
Name: lcd_config_responder

Overview:
- Responder end of the 3-wire LCD serial configuration link (sclk/sdat/scen), as seen by the LTM panel.
- Oversamples the master's pins on the system Clock and decodes 16-bit frames.
- Writes the 8-bit payloads into a 64-entry register file and drives the acknowledge bit back on sdat.
- Used as the panel-side model in system benches and as an on-chip shadow of the panel configuration registers.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/sdat/scen inputs (minimum 2).
- NUM_REGS, 64, register file depth; fixed by the 6-bit address field.
- REG_RESET, 8'h00, reset value of every register file entry.

Ports:
- Clock  input  1  system clock; must be at least 8x the sclk frequency.
- Reset  input  1  asynchronous, active-high reset.
- LCD_I2C_sclk  input  1  serial clock from master.
- LCD_I2C_sdat  inout  1  serial data; this block drives only 0 or 'z.
- LCD_I2C_scen  input  1  frame enable, active low.
- Reg_rd_addr  input  6  combinational lookup address into the register file.
- Reg_rd_data  output  8  register file contents at Reg_rd_addr.
- Frame_valid  output  1  one-Clock pulse when an accepted frame completes.
- Frame_addr  output  6  address of the last accepted frame.
- Frame_data  output  8  data of the last accepted frame.
- Frame_error  output  1  one-Clock pulse on a rejected or aborted frame.

Behaviour:
- Frame format, MSB first: [15:10] register address; [9] RW (0 = write, 1 = read); [8] marker, must be 1; [7:0] data.
- Input sampling:
  - All three pins pass through SYNC_STAGES flops before use.
  - Edges are detected by comparing the last two synchronized samples.
  - The responder samples sdat on sclk rising edges and changes its sdat drive on sclk falling edges.
- State machine:
  - IDLE -> SHIFT on the scen falling edge; bit counter cleared.
  - SHIFT: shift in one bit per sclk rising edge. After the 16th bit go to ACK_WAIT.
  - ACK_WAIT: on the next sclk falling edge, if the frame is valid, drive sdat low and go to ACK; otherwise keep sdat 'z and go to END.
  - ACK: hold sdat low until the following sclk falling edge, then release and go to END.
  - END: wait for scen high, then return to IDLE.
- Frame validity: marker == 1 and RW == 0 (RW rules change under the optional feature).
- Accepted write:
  - Register file entry written on the Clock after the 16th rising edge is detected.
  - Frame_valid pulses in that same cycle; Frame_addr/Frame_data update in that same cycle.
- Rejected frame: Frame_error pulses once, no register write, no acknowledge.
- Abort: scen rising before the 16th bit, from SHIFT or ACK_WAIT:
  - discard the frame, pulse Frame_error, release sdat, return to IDLE.
- scen rising while in ACK: release sdat immediately, return to IDLE; the write already committed stands.
- Bits beyond 16 while scen is still low are ignored.
- A new scen falling edge is honoured only from IDLE.
- Simultaneous scen rise and 16th sclk rise in the same sampled cycle: treated as a completed frame (the edge-count check takes priority).
- Reset (any time, including mid-frame):
  - state IDLE, sdat 'z, Frame_valid 0, Frame_error 0;
  - Frame_addr 0, Frame_data 0, all registers set to REG_RESET.
- Reg_rd_data is combinational from Reg_rd_addr. A write to the same address is visible on the Clock after the write.

Optional Feature:
- Macro: LCD_CFG_READBACK_EN.
- With it defined, frames with RW = 1 are valid reads:
  - on the sclk falling edge after bit 8, the responder drives bits 7..0 of reg[addr] MSB first, using 'z for 1 and 0 for 0 (open-drain);
  - master data bits 7..0 are ignored;
  - the acknowledge follows as for writes;
  - Frame_valid pulses and Frame_data reports the value read.
- Without it, RW = 1 frames are rejected as described above.

Decomposition:
- Shared package lcd_cfg_pkg:
  - frame field widths and bit positions (ADDR_W = 6, DATA_W = 8, RW_BIT = 9, MARK_BIT = 8);
  - the state enum {IDLE, SHIFT, ACK_WAIT, ACK, END}.
- One natural sub-module: lcd_cfg_pin_sync, which provides the synchronizer chain plus rise/fall edge detect for the three pins.

Test Plan:
- Write frame {6'h11, 2'b01, 8'h00} -> sdat low for exactly one sclk period after bit 16; Frame_valid pulse; Frame_addr = 6'h11; reg[0x11] = 8'h00.
- Run the full 20-frame gamma/config sequence; afterwards read back each address:
  - reg[0x14] = 8'h6A, reg[0x20] = 8'hF0, reg[0x03] = 8'hDF, reg[0x04] = 8'h17.
- Frame {6'h05, 2'b00, 8'hAA} (marker 0) -> no acknowledge, Frame_error pulse, reg[0x05] unchanged at 8'h00.
- Raise scen after 9 bits of {6'h12, 2'b01, 8'h55} -> Frame_error pulse, reg[0x12] unchanged; the next full frame is accepted normally.
- Assert Reset during bit 12 of a write, then release -> sdat 'z, all registers 8'h00; the next frame decodes correctly.
- With LCD_CFG_READBACK_EN: write 8'h3C to 6'h21, then read frame {6'h21, 2'b11, 8'h00} -> bits 7..0 on sdat = 0011_1100, then acknowledge; Frame_data = 8'h3C.
